rptr_fwft_handler: RTL and testbench

Read-side pointer handler for the dual-clock async FIFO; it is the counterpart of the write pointer handler and runs entirely in the read clock domain. It compares its registered Gray read pointer against the synchronized write pointer Gray value and drives the RAM read address and read enable. It presents data first-word-fall-through through a 2-entry output stage with a valid/ready handshake, and reports occupancy and almost-empty.

---
 rtl/fifo_ptr_pkg.sv | 24 ++
 rtl/rptr_fwft_stage.sv | 85 ++++++++
 rtl/rptr_fwft_handler.sv | 93 +++++++++
 tb/tb_rptr_fwft_handler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - Gray/binary pointer helpers and constants shared by the FIFO pointer handlers
package fifo_ptr_pkg;

  localparam int GRAY_MAXW       = 32;
  localparam int OUT_STAGE_DEPTH = 2;

  typedef logic [1:0] held_t;

  // Pointers of any width up to GRAY_MAXW are zero-extended on the way in and
  // size-cast back by the caller; zero-extension leaves both codes unchanged.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_fwft_stage.sv
// rtl/rptr_fwft_stage.sv - 2-entry first-word-fall-through output stage with skid slot
module rptr_fwft_stage
  import fifo_ptr_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             in_reset,
  input  logic             capture,
  input  logic [DSIZE-1:0] cap_data,
  input  logic             in_rd_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output held_t            held,
  output held_t            held_next
);

  localparam logic [1:0] HELD_0 = 2'd0;
  localparam logic [1:0] HELD_1 = 2'd1;
  localparam logic [1:0] HELD_2 = 2'd2;

  held_t            held_q, held_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             pop;

  assign pop = (held_q != HELD_0) & in_rd_ready;

  always_comb begin
    held_d = held_q;
    head_d = head_q;
    skid_d = skid_q;
    case (held_q)
      HELD_0: begin
        if (capture) begin
          head_d = cap_data;
          held_d = HELD_1;
        end
      end
      HELD_1: begin
        if (capture && pop) begin
          head_d = cap_data;
        end else if (capture) begin
          skid_d = cap_data;
          held_d = HELD_2;
        end else if (pop) begin
          held_d = HELD_0;
        end
      end
      HELD_2: begin
        // The skid word becomes the head; a same-cycle capture refills the skid slot.
        if (pop) begin
          head_d = skid_q;
          held_d = HELD_1;
          if (capture) begin
            skid_d = cap_data;
            held_d = HELD_2;
          end
        end
      end
      default: held_d = HELD_0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      held_q <= HELD_0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      held_q <= held_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // The credit rule in the parent must never let a word arrive with both slots full.
  assert property (@(posedge clk) disable iff (in_reset) !(capture && !pop && held_q == HELD_2));

  assign out_data  = head_q;
  assign out_valid = (held_q != HELD_0);
  assign held      = held_q;
  assign held_next = held_d;

endmodule

// File: rtl/rptr_fwft_handler.sv
// rtl/rptr_fwft_handler.sv - Read-domain pointer handler for the async FIFO with FWFT output and occupancy
module rptr_fwft_handler
  import fifo_ptr_pkg::*;
#(
  parameter int ASIZE     = 3,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic             rdclk,
  input  logic             in_reset,
  input  logic [ASIZE:0]   sync_wptr_gray,
  input  logic [DSIZE-1:0] rd_data_RAM,
  input  logic             in_rd_ready,
  output logic [ASIZE-1:0] rptr_binary_addr,
  output logic             rd_en_RAM,
  output logic [ASIZE:0]   rptr_gray,
  output logic             out_empty,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic [ASIZE+1:0] out_rd_count,
  output logic             out_almost_empty
);

  localparam int PW = ASIZE + 1;
  localparam int CW = ASIZE + 2;

  logic [ASIZE:0] rptr_bin_q, rptr_bin_d;
  logic [ASIZE:0] rptr_gray_q, rptr_gray_d;
  logic           inflight_q, inflight_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ae_q, ae_d;
  logic [ASIZE:0] wbin;
  logic [ASIZE:0] ptr_diff;
  logic [2:0]     committed;
  logic           pop;
  logic           rd_en;
  held_t          held, held_next;

  assign out_empty = (rptr_gray_q == sync_wptr_gray);
  assign pop       = out_valid & in_rd_ready;

  // Words already pulled from the RAM that will still be unconsumed after this cycle.
  assign committed = 3'(held) + 3'(inflight_q) - 3'(pop);
  assign rd_en     = !in_reset && !out_empty && (committed < 3'(OUT_STAGE_DEPTH));

  assign wbin = PW'(gray2bin(GRAY_MAXW'(sync_wptr_gray)));

  always_comb begin
    rptr_bin_d  = rptr_bin_q + PW'(rd_en);
    rptr_gray_d = PW'(bin2gray(GRAY_MAXW'(rptr_bin_d)));
    inflight_d  = rd_en;
    ptr_diff    = wbin - rptr_bin_d;
    count_d     = CW'(ptr_diff) + CW'(held_next) + CW'(inflight_d);
    ae_d        = (count_d <= CW'(AE_THRESH));
  end

  always_ff @(posedge rdclk) begin
    if (in_reset) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      ae_q        <= 1'b1;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      ae_q        <= ae_d;
    end
  end

  rptr_fwft_stage #(
    .DSIZE(DSIZE)
  ) u_stage (
    .clk        (rdclk),
    .in_reset   (in_reset),
    .capture    (inflight_q),
    .cap_data   (rd_data_RAM),
    .in_rd_ready(in_rd_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .held       (held),
    .held_next  (held_next)
  );

  assign rptr_binary_addr = rptr_bin_q[ASIZE-1:0];
  assign rd_en_RAM        = rd_en;
  assign rptr_gray        = rptr_gray_q;
  assign out_rd_count     = count_q;
  assign out_almost_empty = ae_q;

endmodule

// File: tb/tb_rptr_fwft_handler.sv
// tb/tb_rptr_fwft_handler.sv - Scenario and randomized bench for rptr_fwft_handler against a word-count model
module tb_rptr_fwft_handler;

  localparam int ASIZE = 3;
  localparam int DSIZE = 8;
  localparam int AE_THRESH = 2;
  localparam int DEPTH = 8;

  logic       rdclk = 1'b0;
  logic       in_reset = 1'b1;
  logic [3:0] sync_wptr_gray = '0;
  logic [7:0] rd_data_RAM = '0;
  logic       in_rd_ready = 1'b0;
  logic [2:0] rptr_binary_addr;
  logic       rd_en_RAM;
  logic [3:0] rptr_gray;
  logic       out_empty;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] out_rd_count;
  logic       out_almost_empty;

  rptr_fwft_handler #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AE_THRESH(AE_THRESH)) dut (
    .rdclk(rdclk), .in_reset(in_reset), .sync_wptr_gray(sync_wptr_gray),
    .rd_data_RAM(rd_data_RAM), .in_rd_ready(in_rd_ready),
    .rptr_binary_addr(rptr_binary_addr), .rd_en_RAM(rd_en_RAM), .rptr_gray(rptr_gray),
    .out_empty(out_empty), .out_data(out_data), .out_valid(out_valid),
    .out_rd_count(out_rd_count), .out_almost_empty(out_almost_empty)
  );

  always #5 rdclk = ~rdclk;

  logic [7:0] mem [DEPTH];
  always @(posedge rdclk) if (rd_en_RAM) rd_data_RAM <= mem[rptr_binary_addr];

  int vectors = 0;
  int miscompares = 0;
  int wr_total = 0;
  logic [7:0] exp_q [$];

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic write_word(input logic [7:0] d);
    mem[wr_total % DEPTH] = d;
    exp_q.push_back(d);
    wr_total++;
    sync_wptr_gray = to_gray(wr_total);
  endtask

  task automatic next_cycle();
    @(posedge rdclk);
    #1;
  endtask

  // Ends in the drive slot just after an edge with reset released; write side is reset alongside.
  task automatic do_reset(input int n);
    next_cycle();
    in_reset = 1'b1;
    in_rd_ready = 1'b0;
    wr_total = 0;
    sync_wptr_gray = '0;
    exp_q.delete();
    repeat (n) @(posedge rdclk);
    #1;
    in_reset = 1'b0;
  endtask

  // Model: every written word leaves once in write order; counts derive from words written/read/consumed.
  int m_reads = 0, m_reads_prev = 0, m_popped = 0, m_wvis_prev = 0;
  bit m_rst_prev = 1'b1, m_stall_prev = 1'b0;
  logic [7:0] m_data_prev = '0;

  always @(negedge rdclk) begin
    int exp_cnt;
    bit exp_valid, exp_pop, exp_rd;
    logic [7:0] exp_d;
    logic [3:0] r4, w4;
    if (in_reset) begin
      vectors++;
      if (rd_en_RAM !== 1'b0) begin miscompares++; $display("FAIL rd_en_in_reset: got %b want 0", rd_en_RAM); end
      m_reads = 0; m_reads_prev = 0; m_popped = 0; m_wvis_prev = 0;
      m_rst_prev = 1'b1; m_stall_prev = 1'b0;
    end else begin
      r4 = 4'(m_reads);
      w4 = 4'(wr_total);
      exp_cnt = m_rst_prev ? 0 : (m_wvis_prev - m_popped);
      exp_valid = (m_reads_prev - m_popped) > 0;
      exp_pop = exp_valid && in_rd_ready;
      exp_rd = (r4 != w4) && ((m_reads - m_popped - int'(exp_pop)) < 2);
      vectors++;
      if (out_rd_count !== 5'(exp_cnt)) begin miscompares++; $display("FAIL count: got %0d want %0d", out_rd_count, exp_cnt); end
      vectors++;
      if (out_almost_empty !== (exp_cnt <= AE_THRESH)) begin miscompares++; $display("FAIL almost_empty: got %b want %b", out_almost_empty, exp_cnt <= AE_THRESH); end
      vectors++;
      if (rptr_gray !== to_gray(m_reads)) begin miscompares++; $display("FAIL rptr_gray: got %b want %b", rptr_gray, to_gray(m_reads)); end
      vectors++;
      if (rptr_binary_addr !== 3'(m_reads)) begin miscompares++; $display("FAIL addr: got %0d want %0d", rptr_binary_addr, m_reads % DEPTH); end
      vectors++;
      if (out_empty !== (r4 == w4)) begin miscompares++; $display("FAIL empty: got %b want %b", out_empty, r4 == w4); end
      vectors++;
      if (out_valid !== exp_valid) begin miscompares++; $display("FAIL valid: got %b want %b", out_valid, exp_valid); end
      vectors++;
      if (rd_en_RAM !== exp_rd) begin miscompares++; $display("FAIL rd_en: got %b want %b", rd_en_RAM, exp_rd); end
      if (m_stall_prev) begin
        vectors++;
        if (out_data !== m_data_prev) begin miscompares++; $display("FAIL stall_stable: got %h want %h", out_data, m_data_prev); end
      end
      if (exp_pop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL order: got %h want <no word written>", out_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_data !== exp_d) begin miscompares++; $display("FAIL order: got %h want %h", out_data, exp_d); end
        end
        m_popped++;
      end
      m_stall_prev = exp_valid && !in_rd_ready;
      m_data_prev = out_data;
      m_reads_prev = m_reads;
      if (exp_rd) m_reads++;
      m_wvis_prev = wr_total;
      m_rst_prev = 1'b0;
    end
  end

  task automatic test_reset();
    do_reset(2);
    @(negedge rdclk);
    vectors++;
    if (rd_en_RAM !== 1'b0 || out_valid !== 1'b0 || out_empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_flags: got rd_en=%b valid=%b empty=%b want 0 0 1", rd_en_RAM, out_valid, out_empty);
    end
    vectors++;
    if (out_almost_empty !== 1'b1 || rptr_gray !== 4'd0 || out_rd_count !== 5'd0) begin
      miscompares++; $display("FAIL reset_state: got ae=%b gray=%b count=%0d want 1 0000 0", out_almost_empty, rptr_gray, out_rd_count);
    end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset(2);
    in_rd_ready = 1'b1;
    write_word(8'hA5);
    @(negedge rdclk);
    vectors++;
    if (rd_en_RAM !== 1'b1 || rptr_binary_addr !== 3'd0) begin
      miscompares++; $display("FAIL single_issue: got rd_en=%b addr=%0d want 1 0", rd_en_RAM, rptr_binary_addr);
    end
    next_cycle(); @(negedge rdclk);
    vectors++;
    if (rptr_gray !== 4'b0001 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_t1: got gray=%b valid=%b want 0001 0", rptr_gray, out_valid);
    end
    next_cycle(); @(negedge rdclk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_t2: got valid=%b data=%h want 1 a5", out_valid, out_data);
    end
    next_cycle(); @(negedge rdclk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_t3: got valid=%b want 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_back_pressure();
    logic [7:0] w0;
    int pops;
    do_reset(2);
    w0 = 8'($urandom);
    write_word(w0);
    for (int i = 1; i < 5; i++) write_word(8'($urandom));
    for (int i = 0; i < 6; i++) begin @(negedge rdclk); if (i < 5) next_cycle(); end
    vectors++;
    if (rptr_binary_addr !== 3'd2 || rptr_gray !== 4'b0011 || rd_en_RAM !== 1'b0) begin
      miscompares++; $display("FAIL bp_reads: got addr=%0d gray=%b rd_en=%b want 2 0011 0", rptr_binary_addr, rptr_gray, rd_en_RAM);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== w0) begin
      miscompares++; $display("FAIL bp_hold: got valid=%b data=%h want 1 %h", out_valid, out_data, w0);
    end
    next_cycle();
    in_rd_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge rdclk);
      if (out_valid) pops++;
      next_cycle();
    end
    vectors++;
    if (pops != 5) begin miscompares++; $display("FAIL bp_drain: got %0d words want 5 within 6 cycles", pops); end
  endtask

  task automatic test_wrap();
    int nw, npop, nrd, gaps;
    bit started, seen16;
    do_reset(2);
    in_rd_ready = 1'b1;
    nw = 0; npop = 0; nrd = 0; gaps = 0; started = 1'b0; seen16 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (nw < 20 && (nw - npop) < DEPTH) begin write_word(8'($urandom)); nw++; end
      @(negedge rdclk);
      if (nrd == 16 && !seen16) begin
        seen16 = 1'b1;
        vectors++;
        if (rptr_gray !== 4'b0000) begin miscompares++; $display("FAIL wrap_gray16: got %b want 0000", rptr_gray); end
      end
      if (rd_en_RAM) nrd++;
      if (out_valid) begin started = 1'b1; npop++; end
      else if (started && npop < 20) gaps++;
      next_cycle();
    end
    vectors++;
    if (npop != 20 || nrd != 20 || !seen16) begin
      miscompares++; $display("FAIL wrap_totals: got pops=%0d reads=%0d seen16=%b want 20 20 1", npop, nrd, seen16);
    end
    vectors++;
    if (gaps != 0) begin miscompares++; $display("FAIL wrap_gaps: got %0d want 0", gaps); end
    vectors++;
    if (rptr_gray !== 4'b0110) begin miscompares++; $display("FAIL wrap_gray20: got %b want 0110", rptr_gray); end
  endtask

  task automatic test_count();
    do_reset(2);
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    repeat (5) next_cycle();
    @(negedge rdclk);
    vectors++;
    if (out_rd_count !== 5'd4 || out_almost_empty !== 1'b0) begin
      miscompares++; $display("FAIL count_full: got count=%0d ae=%b want 4 0", out_rd_count, out_almost_empty);
    end
    next_cycle();
    in_rd_ready = 1'b1;
    repeat (2) begin
      @(negedge rdclk);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL count_pop: got valid=%b want 1", out_valid); end
      next_cycle();
    end
    in_rd_ready = 1'b0;
    @(negedge rdclk);
    vectors++;
    if (out_rd_count !== 5'd2 || out_almost_empty !== 1'b1) begin
      miscompares++; $display("FAIL count_after_pop: got count=%0d ae=%b want 2 1", out_rd_count, out_almost_empty);
    end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    int stale;
    bit got_new;
    logic [7:0] wn;
    do_reset(2);
    in_rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(8'($urandom));
    @(negedge rdclk);
    vectors++;
    if (rd_en_RAM !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got rd_en=%b want 1", rd_en_RAM); end
    next_cycle();
    in_reset = 1'b1; wr_total = 0; sync_wptr_gray = '0; exp_q.delete();
    @(negedge rdclk);
    vectors++;
    if (rd_en_RAM !== 1'b0) begin miscompares++; $display("FAIL mid_in_reset: got rd_en=%b want 0", rd_en_RAM); end
    next_cycle();
    in_reset = 1'b0;
    @(negedge rdclk);
    vectors++;
    if (out_valid !== 1'b0 || rptr_gray !== 4'd0 || rd_en_RAM !== 1'b0) begin
      miscompares++; $display("FAIL mid_after: got valid=%b gray=%b rd_en=%b want 0 0000 0", out_valid, rptr_gray, rd_en_RAM);
    end
    stale = 0;
    for (int i = 0; i < 5; i++) begin next_cycle(); @(negedge rdclk); if (out_valid) stale++; end
    vectors++;
    if (stale != 0) begin miscompares++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    next_cycle();
    wn = 8'($urandom);
    write_word(wn);
    got_new = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge rdclk);
      if (out_valid && out_data === wn) got_new = 1'b1;
      next_cycle();
    end
    vectors++;
    if (!got_new) begin miscompares++; $display("FAIL mid_resume: got no word want %h", wn); end
  endtask

  task automatic test_random();
    int tpop;
    do_reset(2);
    tpop = 0;
    for (int c = 0; c < 400; c++) begin
      in_rd_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ((wr_total - tpop) < DEPTH && $urandom_range(0, 2) != 0) write_word(8'($urandom));
      @(negedge rdclk);
      if (out_valid && in_rd_ready) tpop++;
      next_cycle();
    end
    in_rd_ready = 1'b1;
    repeat (20) next_cycle();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL random_drain: got %0d words left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_wrap();
    test_count();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
